// File: rtl/mini_cpu.sv
// Multicycle 8-bit core: FETCH/EXEC/WB per instruction, 4 registers, small data memory.
// Write-back and store events are registered in EXEC and presented during the WB cycle.
module mini_cpu #(
  parameter int DMEM_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic [7:0]                    instruction,
  output logic [7:0]                    address,
  output logic                          halted,
  output logic                          wb_valid,
  output logic [1:0]                    wb_reg,
  output logic [7:0]                    wb_data,
  output logic                          st_valid,
  output logic [$clog2(DMEM_DEPTH)-1:0] st_addr,
  output logic [7:0]                    st_data
);

  localparam int DATA_W = 8;
  localparam int AW     = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic                halted_q, halted_d;
  logic                wb_valid_q, wb_valid_d;
  logic [1:0]          wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                st_valid_q, st_valid_d;
  logic [AW-1:0]       st_addr_q, st_addr_d;
  logic [DATA_W-1:0]   st_data_q, st_data_d;
  logic [DATA_W-1:0]   rf_q [4];
  logic [DATA_W-1:0]   rf_d [4];
  logic [DATA_W-1:0]   mem_q [DMEM_DEPTH];
  logic [DATA_W-1:0]   mem_d [DMEM_DEPTH];

  logic [1:0]          op, rs, rt, rd;
  logic [DATA_W-1:0]   rs_val, rt_val;

  // Base register plus zero-extended immediate, 8-bit sum folded onto the memory size.
  function automatic logic [AW-1:0] eff_addr(input logic [DATA_W-1:0] base,
                                             input logic [1:0]        imm);
    logic [DATA_W-1:0] sum;
    sum = base + {{(DATA_W-2){1'b0}}, imm};
    return sum[AW-1:0];
  endfunction

  assign op     = ir_q[7:6];
  assign rs     = ir_q[5:4];
  assign rt     = ir_q[3:2];
  assign rd     = ir_q[1:0];
  assign rs_val = rf_q[rs];
  assign rt_val = rf_q[rt];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    halted_d   = halted_q;
    wb_valid_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    st_valid_d = 1'b0;
    st_addr_d  = st_addr_q;
    st_data_d  = st_data_q;
    rf_d       = rf_q;
    mem_d      = mem_q;

    case (state_q)
      FETCH: begin
        ir_d    = instruction;
        state_d = EXEC;
      end
      EXEC: begin
        // Operands are captured here; the architectural write lands one cycle later.
        case (op)
          2'b00: begin
            wb_valid_d = 1'b1;
            wb_reg_d   = rd;
            wb_data_d  = rs_val + rt_val;
            state_d    = WB;
          end
          2'b01: begin
            wb_valid_d = 1'b1;
            wb_reg_d   = rt;
            wb_data_d  = mem_q[eff_addr(rs_val, rd)];
            state_d    = WB;
          end
          2'b10: begin
            st_valid_d = 1'b1;
            st_addr_d  = eff_addr(rs_val, rd);
            st_data_d  = rt_val;
            state_d    = WB;
          end
          default: begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
        endcase
      end
      WB: begin
        if (wb_valid_q) rf_d[wb_reg_q] = wb_data_q;
        if (st_valid_q) mem_d[st_addr_q] = st_data_q;
        pc_d    = pc_q + 8'd1;
        state_d = FETCH;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      halted_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      st_valid_q <= 1'b0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= DATA_W'(i);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      halted_q   <= halted_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      st_valid_q <= st_valid_d;
      st_addr_q  <= st_addr_d;
      st_data_q  <= st_data_d;
      rf_q       <= rf_d;
      mem_q      <= mem_d;
    end
  end

  assign address  = pc_q;
  assign halted   = halted_q;
  assign wb_valid = wb_valid_q;
  assign wb_reg   = wb_reg_q;
  assign wb_data  = wb_data_q;
  assign st_valid = st_valid_q;
  assign st_addr  = st_addr_q;
  assign st_data  = st_data_q;

endmodule

// File: tb/tb_mini_cpu.sv
// Directed bench for mini_cpu: ROM model, event trace capture and hand-computed expectations.
module tb_mini_cpu;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] instruction;
  logic [7:0] address;
  logic       halted;
  logic       wb_valid;
  logic [1:0] wb_reg;
  logic [7:0] wb_data;
  logic       st_valid;
  logic [2:0] st_addr;
  logic [7:0] st_data;

  logic [7:0] rom [256];
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int halt_cyc = -1;
  int both_hi = 0;
  int wbr_q[$];
  int wbd_q[$];
  int wbc_q[$];
  int sta_q[$];
  int std_q[$];
  int stc_q[$];

  // Reference program expectations (reg, data, cycle of WB event)
  int ref_wbr[9] = '{1, 2, 0, 3, 1, 0, 3, 2, 0};
  int ref_wbd[9] = '{1, 2, 3, 1, 4, 2, 6, 6, 12};
  int ref_wbc[9] = '{2, 5, 8, 11, 14, 20, 23, 29, 32};
  int ref_sta[2] = '{1, 2};
  int ref_std[2] = '{4, 6};
  int ref_stc[2] = '{17, 26};

  // Overflow / wrap / self-reference program expectations
  int p2_wbr[16] = '{1, 2, 2, 2, 3, 1, 1, 1, 0, 2, 1, 1, 3, 0, 1, 0};
  int p2_wbd[16] = '{3, 6, 12, 24, 1, 25, 50, 100, 200, 44, 4, 8, 16, 7, 2, 6};

  assign instruction = ovr_en ? ovr_val : rom[address];

  mini_cpu #(.DMEM_DEPTH(8)) dut (
    .clk        (clk),
    .clear      (clear),
    .instruction(instruction),
    .address    (address),
    .halted     (halted),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    wbr_q.delete(); wbd_q.delete(); wbc_q.delete();
    sta_q.delete(); std_q.delete(); stc_q.delete();
    both_hi  = 0;
    halt_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (wb_valid) begin
      wbr_q.push_back(int'(wb_reg));
      wbd_q.push_back(int'(wb_data));
      wbc_q.push_back(cyc);
    end
    if (st_valid) begin
      sta_q.push_back(int'(st_addr));
      std_q.push_back(int'(st_data));
      stc_q.push_back(cyc);
    end
    if (wb_valid && st_valid) both_hi++;
    if (halted && halt_cyc < 0) halt_cyc = cyc;
  endtask

  task automatic release_clear();
    clear = 1'b1;
    cyc   = 0;
    clr_log();
  endtask

  task automatic run_until_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
    chk("halt_within_budget", halted, 1);
  endtask

  task automatic load_ref_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
    rom[0]  = 8'h45; rom[1]  = 8'h4A; rom[2]  = 8'h18; rom[3]  = 8'h7D;
    rom[4]  = 8'h0D; rom[5]  = 8'hB4; rom[6]  = 8'h71; rom[7]  = 8'h1B;
    rom[8]  = 8'h8C; rom[9]  = 8'h48; rom[10] = 8'h2C; rom[11] = 8'hC0;
  endtask

  task automatic load_p2_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
    rom[0]  = 8'h47; rom[1]  = 8'h16; rom[2]  = 8'h2A; rom[3]  = 8'h2A;
    rom[4]  = 8'h4D; rom[5]  = 8'h2D; rom[6]  = 8'h15; rom[7]  = 8'h15;
    rom[8]  = 8'h14; rom[9]  = 8'h06; rom[10] = 8'h77; rom[11] = 8'h15;
    rom[12] = 8'h17; rom[13] = 8'h63; rom[14] = 8'h47; rom[15] = 8'h62;
    rom[16] = 8'h8F; rom[17] = 8'hC0;
  endtask

  initial begin
    load_ref_rom();

    // Reset state
    @(negedge clk);
    chk("rst_address", address, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_wb_reg", wb_reg, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_st_addr", st_addr, 0);
    chk("rst_st_data", st_data, 0);
    release_clear();

    // Clear asserted during EXEC of instruction 4
    repeat (13) tick();
    chk("mid_pre_address", address, 4);
    chk("mid_pre_wb_count", wbd_q.size(), 4);
    clear = 1'b0;
    #1;
    chk("mid_address", address, 0);
    chk("mid_wb_valid", wb_valid, 0);
    chk("mid_wb_data", wb_data, 0);
    chk("mid_halted", halted, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_no_wb_event", wb_valid, 0);
    chk("mid_no_st_event", st_valid, 0);
    chk("mid_hold_address", address, 0);
    release_clear();

    // Reference program from a fresh start
    run_until_halt(60);
    chk("ref_halt_cycle", halt_cyc, 35);
    chk("ref_final_address", address, 11);
    chk("ref_wb_count", wbd_q.size(), 9);
    chk("ref_st_count", std_q.size(), 2);
    chk("ref_both_valid", both_hi, 0);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("ref_wb_reg[%0d]", i), (i < wbr_q.size()) ? wbr_q[i] : -1, ref_wbr[i]);
      chk($sformatf("ref_wb_data[%0d]", i), (i < wbd_q.size()) ? wbd_q[i] : -1, ref_wbd[i]);
      chk($sformatf("ref_wb_cycle[%0d]", i), (i < wbc_q.size()) ? wbc_q[i] : -1, ref_wbc[i]);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ref_st_addr[%0d]", i), (i < sta_q.size()) ? sta_q[i] : -1, ref_sta[i]);
      chk($sformatf("ref_st_data[%0d]", i), (i < std_q.size()) ? std_q[i] : -1, ref_std[i]);
      chk($sformatf("ref_st_cycle[%0d]", i), (i < stc_q.size()) ? stc_q[i] : -1, ref_stc[i]);
    end

    // Halt hold with a toggling instruction bus
    clr_log();
    ovr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ovr_val = (i % 2 == 0) ? 8'h45 : 8'h0D;
      tick();
      chk($sformatf("hold_halted[%0d]", i), halted, 1);
      chk($sformatf("hold_address[%0d]", i), address, 11);
    end
    chk("hold_wb_events", wbd_q.size(), 0);
    chk("hold_st_events", std_q.size(), 0);
    ovr_en = 1'b0;

    // Clear while halted, then overflow / wrap / self-reference program
    load_p2_rom();
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("halt_clear_halted", halted, 0);
    chk("halt_clear_address", address, 0);
    @(negedge clk);
    release_clear();
    run_until_halt(80);
    chk("p2_halt_cycle", halt_cyc, 53);
    chk("p2_final_address", address, 17);
    chk("p2_wb_count", wbd_q.size(), 16);
    chk("p2_st_count", std_q.size(), 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("p2_wb_reg[%0d]", i), (i < wbr_q.size()) ? wbr_q[i] : -1, p2_wbr[i]);
      chk($sformatf("p2_wb_data[%0d]", i), (i < wbd_q.size()) ? wbd_q[i] : -1, p2_wbd[i]);
    end
    chk("p2_st_addr_wrap", (sta_q.size() > 0) ? sta_q[0] : -1, 1);
    chk("p2_st_data", (std_q.size() > 0) ? std_q[0] : -1, 16);
    chk("p2_st_cycle", (stc_q.size() > 0) ? stc_q[0] : -1, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
